rf_writeback_ctrl: RTL and testbench
====================================

// Module: rf_writeback_ctrl
// PURPOSE
// - Drives the register file write port for the multi-cycle MIPS core: selects destination
//   register, selects/forms write data (ALU result, link address, or aligned/extended load data),
//   sequences the data-memory read for loads, and pulses instr_done to request the next fetch.
// - Sits between execute/memory stages and the register file.
// PARAMETERS
// - LINK_REG   31  register written by JAL/JALR-less links (JAL, BLTZAL, BGEZAL)
// PORTS
// - clk             in   1   clock, all state on rising edge
// - reset           in   1   synchronous, active-high
// - start           in   1   instruction ready for writeback; sampled only in IDLE
// - instr           in   32  instruction word
// - alu_result      in   32  ALU output; effective address for loads
// - pc_plus8        in   32  link value
// - rt_value        in   32  current rt contents (LWL/LWR merge)
// - mem_readdata    in   32  data-memory read data, valid when mem_read & !mem_waitrequest
// - mem_waitrequest in   1   memory stall
// - mem_read        out  1   data-memory read request
// - mem_address     out  32  {addr[31:2],2'b00}
// - rf_write_en     out  1   register file write strobe
// - rf_write_addr   out  5   destination register
// - rf_write_data   out  32  write data
// - busy            out  1   high in any state except IDLE
// - instr_done      out  1   one-cycle pulse: writeback complete
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0. Reset mid-load drops mem_read next edge, no write, no done.
// - start in IDLE latches instr, alu_result, pc_plus8, rt_value; start ignored while busy.
// - Dest decode (captured instr): opcode 0x00 -> rd, except funct 0x08 JR, 0x11/0x13 MTHI/MTLO,
//   0x18-0x1B MULT/DIV: no write; JALR (0x09) -> rd with pc_plus8. 0x03 JAL -> LINK_REG, pc_plus8.
//   0x01 with rt 0x10/0x11 -> LINK_REG, pc_plus8 (written even if branch not taken).
//   0x09,0x0A-0x0F -> rt, alu_result. Loads 0x20-0x26 -> rt. Everything else: no write.
// - FSM IDLE -> WRITE (non-load, or no-write op) | MEM (load).
//   MEM: mem_read=1, address held; stays while mem_waitrequest=1; on accept cycle capture
//   mem_readdata -> WRITE. mem_read drops the cycle after accept.
//   WRITE: one cycle; rf_write_en=1 unless no-write or dest==0; instr_done=1; -> IDLE.
// - Latency: ALU op start at cycle N -> write/done at N+1. Load: mem_read N+1; accept at cycle A
//   -> write/done at A+1. Back-to-back start accepted in the cycle after done.
// - Load data (little-endian, k=addr[1:0]): LB/LBU byte k sign/zero-extend; LH/LHU half k[1]
//   (k[0] ignored, no exception); LW full word, k ignored.
//   LWL k=0 {m[7:0],rt[23:0]}, 1 {m[15:0],rt[15:0]}, 2 {m[23:0],rt[7:0]}, 3 m.
//   LWR k=0 m, 1 {rt[31:24],m[31:8]}, 2 {rt[31:16],m[31:16]}, 3 {rt[31:8],m[31:24]}.
// - rf_write_addr/rf_write_data held stable in WRITE only; 0 elsewhere.
// STRUCTURE
// - mips_pkg: opcode/funct constants, wb_state_t enum {IDLE, MEM, WRITE}, wb_src_t enum.
// - Sub-module load_align (combinational): (funct op, k, mem_word, rt) -> 32-bit write data.
// - Top: capture registers, dest/source decode, FSM, output registers.
// TESTING
// - ADDIU rt=5, alu=0x1234, start -> next cycle en=1 addr=5 data=0x1234, done=1.
// - ORI rt=0 -> done pulse, rf_write_en stays 0.
// - LB addr=0x1003, waitrequest high 3 cycles, word 0x80FF_0000 -> data 0xFFFFFF80 to rt, done
//   1 cycle after accept; mem_address=0x1000 held throughout.
// - LWR addr k=2, rt=0xAABBCCDD, m=0x11223344 -> 0xAABB1122; LWL k=1 -> 0x3344CCDD.
// - JAL -> addr 31 data=pc_plus8; JR -> no write, done; start pulsed while busy -> ignored.
// - reset asserted during MEM wait -> mem_read 0 next cycle, no write, no done, busy 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS writeback path.
// Opcode/funct codes, writeback FSM states and write-data source select.
package mips_pkg;

  localparam logic [4:0] LINK_REG = 5'd31;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MTLO    = 6'h13;

  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    WRITE
  } wb_state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LINK,
    SRC_MEM
  } wb_src_t;

  function automatic logic is_load(
    input logic [5:0] op
  );
    return (op >= OP_LB) && (op <= OP_LWR);
  endfunction

endpackage

// File: rtl/load_align.sv
// Aligns, extends and merges a little-endian memory word for loads.
// op: load opcode, k: addr[1:0], mem_word/rt: inputs, data: result.
module load_align
  import mips_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  k,
  input  logic [31:0] mem_word,
  input  logic [31:0] rt,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    unique case (k)
      2'd0: byte_sel = mem_word[7:0];
      2'd1: byte_sel = mem_word[15:8];
      2'd2: byte_sel = mem_word[23:16];
      2'd3: byte_sel = mem_word[31:24];
    endcase
    half_sel = k[1] ? mem_word[31:16]
                    : mem_word[15:0];
  end

  always_comb begin
    data = mem_word;
    unique case (1'b1)
      op == OP_LB:
        data = {{24{byte_sel[7]}}, byte_sel};
      op == OP_LBU:
        data = {24'h0, byte_sel};
      op == OP_LH:
        data = {{16{half_sel[15]}}, half_sel};
      op == OP_LHU:
        data = {16'h0, half_sel};
      op == OP_LWL: begin
        unique case (k)
          2'd0: data = {mem_word[7:0], rt[23:0]};
          2'd1: data = {mem_word[15:0], rt[15:0]};
          2'd2: data = {mem_word[23:0], rt[7:0]};
          2'd3: data = mem_word;
        endcase
      end
      op == OP_LWR: begin
        unique case (k)
          2'd0: data = mem_word;
          2'd1: data = {rt[31:24], mem_word[31:8]};
          2'd2: data = {rt[31:16], mem_word[31:16]};
          2'd3: data = {rt[31:8], mem_word[31:24]};
        endcase
      end
      default: data = mem_word;
    endcase
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register file write port control: dest/source decode, load sequencing.
// Ports: start/instr/operands in, data-memory read port, rf write port, busy/done.
module rf_writeback_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc_plus8,
  input  logic [31:0] rt_value,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        mem_read,
  output logic [31:0] mem_address,
  output logic        rf_write_en,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic        busy,
  output logic        instr_done
);

  wb_state_t   state, state_nxt;
  logic [5:0]  op_q, fn_q;
  logic [4:0]  rt_q, rd_q;
  logic [31:0] alu_q, pc8_q, rtv_q, ld_q;
  logic [31:0] ld_aligned;
  logic [4:0]  dest;
  wb_src_t     src;
  logic        accept;
  logic        unused_instr;

  assign unused_instr = ^{instr[25:21], instr[10:6]};
  assign accept = (state == MEM) && !mem_waitrequest;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= '0;
      fn_q  <= '0;
      rt_q  <= '0;
      rd_q  <= '0;
      alu_q <= '0;
      pc8_q <= '0;
      rtv_q <= '0;
      ld_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        op_q  <= instr[31:26];
        rt_q  <= instr[20:16];
        rd_q  <= instr[15:11];
        fn_q  <= instr[5:0];
        alu_q <= alu_result;
        pc8_q <= pc_plus8;
        rtv_q <= rt_value;
      end
      if (accept) ld_q <= ld_aligned;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (start)
          state_nxt = is_load(instr[31:26])
                    ? MEM : WRITE;
      MEM:
        if (!mem_waitrequest)
          state_nxt = WRITE;
      WRITE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  load_align u_align (
    .op       (op_q),
    .k        (alu_q[1:0]),
    .mem_word (mem_readdata),
    .rt       (rtv_q),
    .data     (ld_aligned)
  );

  always_comb begin
    dest = 5'd0;
    src  = SRC_NONE;
    unique case (1'b1)
      op_q == OP_SPECIAL: begin
        if (fn_q == FN_JALR) begin
          dest = rd_q;
          src  = SRC_LINK;
        end else if (fn_q != FN_JR &&
                     fn_q != FN_MTHI &&
                     fn_q != FN_MTLO &&
                     fn_q[5:2] != 4'h6) begin
          dest = rd_q;
          src  = SRC_ALU;
        end
      end
      op_q == OP_REGIMM: begin
        if (rt_q == RT_BLTZAL ||
            rt_q == RT_BGEZAL) begin
          dest = LINK_REG;
          src  = SRC_LINK;
        end
      end
      op_q == OP_JAL: begin
        dest = LINK_REG;
        src  = SRC_LINK;
      end
      op_q >= OP_ADDIU && op_q <= 6'h0F: begin
        dest = rt_q;
        src  = SRC_ALU;
      end
      is_load(op_q): begin
        dest = rt_q;
        src  = SRC_MEM;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_read      = (state == MEM);
    mem_address   = mem_read
                  ? {alu_q[31:2], 2'b00} : '0;
    busy          = (state != IDLE);
    instr_done    = (state == WRITE);
    rf_write_en   = instr_done &&
                    src != SRC_NONE &&
                    dest != 5'd0;
    rf_write_addr = instr_done ? dest : '0;
    rf_write_data = '0;
    if (instr_done) begin
      unique case (src)
        SRC_ALU:  rf_write_data = alu_q;
        SRC_LINK: rf_write_data = pc8_q;
        SRC_MEM:  rf_write_data = ld_q;
        default:  rf_write_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed testbench for rf_writeback_ctrl.
// Inputs driven and outputs checked on the falling clock edge.
module tb_rf_writeback_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instr, alu_result, pc_plus8;
  logic [31:0] rt_value, mem_readdata;
  logic        mem_waitrequest;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        busy, instr_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_writeback_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .instr           (instr),
    .alu_result      (alu_result),
    .pc_plus8        (pc_plus8),
    .rt_value        (rt_value),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest),
    .mem_read        (mem_read),
    .mem_address     (mem_address),
    .rf_write_en     (rf_write_en),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .busy            (busy),
    .instr_done      (instr_done)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] itype(
    input logic [5:0]  op,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    return {op, 5'd3, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(
    input logic [4:0] rd,
    input logic [5:0] fn
  );
    return {6'h00, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction

  task automatic do_op(
    input string       tag,
    input logic [31:0] ins,
    input logic [31:0] alu,
    input logic        e_en,
    input logic [4:0]  e_addr,
    input logic [31:0] e_data
  );
    instr      = ins;
    alu_result = alu;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    chk({tag, ".done"}, 32'(instr_done), 1);
    chk({tag, ".en"}, 32'(rf_write_en), 32'(e_en));
    if (e_en) begin
      chk({tag, ".addr"}, 32'(rf_write_addr),
          32'(e_addr));
      chk({tag, ".data"}, rf_write_data, e_data);
    end
    @(negedge clk);
    chk({tag, ".idle"},
        32'({busy, instr_done, rf_write_en}), 0);
  endtask

  task automatic do_load(
    input string       tag,
    input logic [31:0] ins,
    input logic [31:0] alu,
    input logic [31:0] rtv,
    input logic [31:0] m,
    input logic [4:0]  e_addr,
    input logic [31:0] e_data
  );
    instr           = ins;
    alu_result      = alu;
    rt_value        = rtv;
    mem_waitrequest = 1'b0;
    mem_readdata    = m;
    start           = 1'b1;
    @(negedge clk);
    start           = 1'b0;
    chk({tag, ".rd"}, 32'(mem_read), 1);
    @(negedge clk);
    chk({tag, ".en"}, 32'(rf_write_en), 1);
    chk({tag, ".addr"}, 32'(rf_write_addr),
        32'(e_addr));
    chk({tag, ".data"}, rf_write_data, e_data);
    @(negedge clk);
  endtask

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    instr           = '0;
    alu_result      = '0;
    pc_plus8        = 32'h0040_0010;
    rt_value        = '0;
    mem_readdata    = '0;
    mem_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.outs",
        32'({mem_read, rf_write_en, busy,
             instr_done}), 0);
    chk("rst.data", rf_write_data, 0);
    chk("rst.maddr", mem_address, 0);
    reset = 1'b0;
    @(negedge clk);

    do_op("addiu", itype(6'h09, 5'd5, 16'h1234),
          32'h1234, 1'b1, 5'd5, 32'h1234);
    do_op("ori_r0", itype(6'h0D, 5'd0, 16'h00FF),
          32'h00FF, 1'b0, 5'd0, 32'h0);
    do_op("jal", {6'h03, 26'h10},
          32'hDEAD, 1'b1, 5'd31, 32'h0040_0010);
    do_op("jr", rtype(5'd0, 6'h08),
          32'hBEEF, 1'b0, 5'd0, 32'h0);
    do_op("mult", rtype(5'd4, 6'h18),
          32'h5, 1'b0, 5'd0, 32'h0);
    do_op("addu", rtype(5'd12, 6'h21),
          32'h7777, 1'b1, 5'd12, 32'h7777);
    do_op("jalr", rtype(5'd6, 6'h09),
          32'h1, 1'b1, 5'd6, 32'h0040_0010);
    do_op("bgezal", itype(6'h01, 5'h11, 16'h4),
          32'h2, 1'b1, 5'd31, 32'h0040_0010);
    do_op("beq", itype(6'h04, 5'd7, 16'h4),
          32'h3, 1'b0, 5'd0, 32'h0);

    // LB with stall; a start pulse while busy must be ignored.
    instr           = itype(6'h20, 5'd7, 16'h1003);
    alu_result      = 32'h0000_1003;
    mem_waitrequest = 1'b1;
    mem_readdata    = 32'hFFFF_FFFF;
    start           = 1'b1;
    @(negedge clk);
    start           = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lb.rd", 32'(mem_read), 1);
      chk("lb.maddr", mem_address, 32'h1000);
      chk("lb.done", 32'(instr_done), 0);
      chk("lb.busy", 32'(busy), 1);
      if (i == 1) begin
        instr      = itype(6'h09, 5'd9, 16'h5);
        alu_result = 32'h5;
        start      = 1'b1;
      end else begin
        start      = 1'b0;
      end
      @(negedge clk);
    end
    mem_waitrequest = 1'b0;
    mem_readdata    = 32'h80FF_0000;
    chk("lb.acc.rd", 32'(mem_read), 1);
    chk("lb.acc.maddr", mem_address, 32'h1000);
    @(negedge clk);
    mem_readdata    = 32'h0;
    chk("lb.wr.rd", 32'(mem_read), 0);
    chk("lb.wr.done", 32'(instr_done), 1);
    chk("lb.wr.en", 32'(rf_write_en), 1);
    chk("lb.wr.addr", 32'(rf_write_addr), 7);
    chk("lb.wr.data", rf_write_data, 32'hFFFF_FF80);
    @(negedge clk);
    chk("lb.after",
        32'({busy, instr_done, mem_read}), 0);

    do_load("lwr", itype(6'h26, 5'd8, 16'h0),
            32'h2002, 32'hAABB_CCDD,
            32'h1122_3344, 5'd8, 32'hAABB_1122);
    do_load("lwl", itype(6'h22, 5'd8, 16'h0),
            32'h3001, 32'hAABB_CCDD,
            32'h1122_3344, 5'd8, 32'h3344_CCDD);
    do_load("lhu", itype(6'h25, 5'd10, 16'h0),
            32'h4003, 32'h0,
            32'h8765_4321, 5'd10, 32'h0000_8765);
    do_load("lh", itype(6'h21, 5'd11, 16'h0),
            32'h4001, 32'h0,
            32'h1234_9ABC, 5'd11, 32'hFFFF_9ABC);
    do_load("lw", itype(6'h23, 5'd13, 16'h0),
            32'h5002, 32'h0,
            32'hCAFE_F00D, 5'd13, 32'hCAFE_F00D);

    // Reset while stalled in MEM.
    instr           = itype(6'h23, 5'd14, 16'h0);
    alu_result      = 32'h6000;
    mem_waitrequest = 1'b1;
    start           = 1'b1;
    @(negedge clk);
    start           = 1'b0;
    chk("rstm.rd", 32'(mem_read), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstm.outs",
        32'({mem_read, rf_write_en, busy,
             instr_done}), 0);
    reset           = 1'b0;
    mem_waitrequest = 1'b0;
    @(negedge clk);
    chk("rstm.after",
        32'({mem_read, rf_write_en, busy,
             instr_done}), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 1 exp 0");
    $fatal(1);
  end

endmodule
